// File: rtl/ren_conv_pkg.sv
// Shared definitions for the convolver result-drain block.
//   drain_state_e     : drain FSM state encoding
//   RESULT_WIN_OFFSET : byte offset of the result RAM window in the convolver map
//   LANES             : bytes packed per stream word
//   keep_mask()       : byte-keep mask for a given number of filled lanes
package ren_conv_pkg;

  localparam int unsigned LANES = 4;
  localparam logic [9:0] RESULT_WIN_OFFSET = 10'h300;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StGap  = 3'd2,
    StOut  = 3'd3,
    StDone = 3'd4
  } drain_state_e;

  // (1 << filled) - 1, computed one bit wider so filled == LANES gives all ones.
  function automatic logic [LANES-1:0] keep_mask(input logic [2:0] filled);
    logic [LANES:0] m;
    m = ({{LANES{1'b0}}, 1'b1} << filled) - 1'b1;
    return m[LANES-1:0];
  endfunction

endpackage

// File: rtl/ren_byte_packer.sv
// Little-endian byte packer: collects up to LANES bytes into one stream word.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : drop the current word (after a handshake or an abort)
//   wr_i       : write byte_i into lane lane_i; last_i marks the drain's final entry
//   data_o     : packed word, lane j in bits [8j+7:8j]; unwritten lanes read 0
//   keep_o     : mask of filled lanes
//   last_o     : word holds the final entry of the drain
module ren_byte_packer
  import ren_conv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               wr_i,
  input  logic [1:0]         lane_i,
  input  logic [7:0]         byte_i,
  input  logic               last_i,
  output logic [8*LANES-1:0] data_o,
  output logic [LANES-1:0]   keep_o,
  output logic               last_o
);

  logic [LANES-1:0][7:0] lane_q;
  logic [2:0]            fill_q;
  logic                  last_q;

  // Lanes fill in order, so the fill count is simply the last written lane + 1.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      lane_q <= '0;
      fill_q <= '0;
      last_q <= 1'b0;
    end else if (wr_i) begin
      lane_q[lane_i] <= byte_i;
      fill_q         <= {1'b0, lane_i} + 3'd1;
      last_q         <= last_i;
    end
  end

  assign data_o = lane_q;
  assign keep_o = keep_mask(fill_q);
  assign last_o = last_q;

endmodule

// File: rtl/ren_conv_result_drain.sv
// Result drain: reads count 8-bit entries from the convolver result window with single
// Wishbone read cycles and streams them packed four per 32-bit word (valid/ready, keep, last).
//   clk, reset           : clock, synchronous active-high reset
//   start, base_addr,
//   count                : drain request, sampled in idle only
//   busy, done           : drain in progress, one-cycle completion/abort pulse
//   wbm_*                : Wishbone master (read only, full byte select)
//   m_valid, m_data,
//   m_keep, m_last,
//   m_ready              : packed result stream
//   err                  : sticky ack-timeout abort flag
// Optional: define REN_DRAIN_TIMEOUT_EN to abort a read whose ack does not arrive within
// TIMEOUT_CYCLES; without it a read waits indefinitely and err is 0.
module ren_conv_result_drain
  import ren_conv_pkg::*;
#(
  parameter int unsigned RSLT_ADDR_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [RSLT_ADDR_WIDTH:0]  count,
  output logic                      busy,
  output logic                      done,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [3:0]                wbm_sel_o,
  output logic [ADDR_WIDTH-1:0]     wbm_adr_o,
  input  logic [31:0]               wbm_dat_i,
  input  logic                      wbm_ack_i,
  output logic                      m_valid,
  output logic [31:0]               m_data,
  output logic [3:0]                m_keep,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      err
);

  localparam int unsigned IW = RSLT_ADDR_WIDTH + 1;

  drain_state_e          state_q;
  logic                  busy_q, done_q, cyc_q, valid_q;
  logic [ADDR_WIDTH-1:0] base_q, adr_q, next_adr;
  logic [IW-1:0]         count_q, idx_q, idx_inc;
  logic                  cap, last_ent, word_full, out_hs, tmo_hit;

  assign idx_inc   = idx_q + 1'b1;
  assign cap       = (state_q == StReq) && wbm_ack_i;
  assign last_ent  = (idx_inc == count_q);
  assign word_full = (idx_q[1:0] == 2'd3);
  assign out_hs    = (state_q == StOut) && m_ready;
  assign next_adr  = base_q + (ADDR_WIDTH'(idx_q) << 2);

`ifdef REN_DRAIN_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q;
  logic            err_q;

  assign tmo_hit = (state_q == StReq) && !wbm_ack_i &&
                   (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside REQ, so every entry into REQ starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start) begin
        err_q <= 1'b0;
      end else if (tmo_hit) begin
        err_q <= 1'b1;
      end
      if (state_q != StReq) begin
        tmo_q <= '0;
      end else if (!wbm_ack_i) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= 1'b0;
      valid_q <= 1'b0;
      base_q  <= '0;
      adr_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= count;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            if (count == '0) begin
              state_q <= StDone;
            end else begin
              state_q <= StReq;
              cyc_q   <= 1'b1;
              adr_q   <= base_addr;
            end
          end
        end
        StReq: begin
          if (wbm_ack_i) begin
            cyc_q <= 1'b0;
            idx_q <= idx_inc;
            if (word_full || last_ent) begin
              state_q <= StOut;
              valid_q <= 1'b1;
            end else begin
              state_q <= StGap;
            end
          end else if (tmo_hit) begin
            cyc_q   <= 1'b0;
            state_q <= StDone;
          end
        end
        // One dead bus cycle so the slave's ack is gone before the next strobe.
        StGap: begin
          state_q <= StReq;
          cyc_q   <= 1'b1;
          adr_q   <= next_adr;
        end
        StOut: begin
          if (m_ready) begin
            valid_q <= 1'b0;
            state_q <= (idx_q == count_q) ? StDone : StGap;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ren_byte_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (out_hs || tmo_hit),
    .wr_i   (cap),
    .lane_i (idx_q[1:0]),
    .byte_i (wbm_dat_i[7:0]),
    .last_i (last_ent),
    .data_o (m_data),
    .keep_o (m_keep),
    .last_o (m_last)
  );

  logic [23:0] unused_dat;
  assign unused_dat = wbm_dat_i[31:8];

  assign busy      = busy_q;
  assign done      = done_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = adr_q;
  assign m_valid   = valid_q;

endmodule

// File: tb/tb_ren_conv_result_drain.sv
module tb_ren_conv_result_drain;
  import ren_conv_pkg::*;

  localparam int RAW = 6;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          reset, start, m_ready;
  logic [AW-1:0] base_addr;
  logic [RAW:0]  count;
  logic          busy, done, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]    wbm_sel_o, m_keep;
  logic [AW-1:0] wbm_adr_o;
  logic [31:0]   wbm_dat_i, m_data;
  logic          m_valid, m_last, err;

  always #5 clk = ~clk;

  ren_conv_result_drain #(
    .RSLT_ADDR_WIDTH (RAW),
    .ADDR_WIDTH      (AW),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .err       (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: result memory, random ack latency, optional ack suppression.
  logic [7:0]    mem [0:63];
  logic [AW-1:0] sl_base = '0;
  logic [AW-1:0] sl_off;
  int            sl_lat_max = 0;
  bit            sl_ack_en = 1'b1;
  logic          ack_q = 1'b0;
  logic          stray_ack = 1'b0;
  logic [31:0]   rdata_q = '0;
  logic [AW-1:0] adr_log [$];

  assign sl_off    = (wbm_adr_o - sl_base) >> 2;
  assign wbm_ack_i = ack_q | stray_ack;
  assign wbm_dat_i = rdata_q;

  always @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
    end else if (ack_q) begin
      ack_q <= 1'b0;
    end else if (wbm_cyc_o && wbm_stb_o && sl_ack_en &&
                 (sl_lat_max == 0 || $urandom_range(0, sl_lat_max) == 0)) begin
      ack_q   <= 1'b1;
      rdata_q <= {24'($urandom()), mem[sl_off[5:0]]};
      adr_log.push_back(wbm_adr_o);
    end
  end

  // Stream and bus monitors.
  logic [31:0] got_data [$];
  logic [3:0]  got_keep [$];
  logic        got_last [$];
  int done_cnt = 0, cyc_cycles = 0, stb_cycles = 0, valid_cycles = 0;
  int bus_viol = 0, stall_viol = 0;
  logic        hold_q = 1'b0;
  logic [36:0] held_q = '0;

  always @(posedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_keep.push_back(m_keep);
        got_last.push_back(m_last);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (wbm_cyc_o) cyc_cycles <= cyc_cycles + 1;
      if (wbm_stb_o) stb_cycles <= stb_cycles + 1;
      if (m_valid) valid_cycles <= valid_cycles + 1;
      if (m_valid && wbm_cyc_o) bus_viol <= bus_viol + 1;
      if (hold_q && !(m_valid && {m_data, m_keep, m_last} == held_q))
        stall_viol <= stall_viol + 1;
      hold_q <= m_valid && !m_ready;
      held_q <= {m_data, m_keep, m_last};
    end
  end

  // Runs one drain of n entries from mem[] and checks it against the stream model.
  // rmode: 0 ready always high, 1 random ready, 2 first word stalled 10 cycles.
  task automatic run_drain(input int n, input logic [AW-1:0] base, input int lat,
                           input int rmode, input string tag, output int done_at);
    int w0, a0, d0, k, stall_n, nw, filled;
    logic [31:0] ed;
    w0 = got_data.size(); a0 = adr_log.size(); d0 = done_cnt;
    done_at = -1; k = 0; stall_n = 0;
    sl_base = base; sl_lat_max = lat;
    @(negedge clk);
    base_addr = base; count = 7'(n); start = 1'b1;
    m_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (done_at < 0 && k < 40 * n + 60) begin
      @(posedge clk); k++;
      @(negedge clk);
      start = 1'b0; base_addr = $urandom(); count = 7'($urandom());
      if (done) done_at = k;
      case (rmode)
        1: m_ready = 1'($urandom_range(0, 1));
        2: if (m_valid && stall_n < 10) begin m_ready = 1'b0; stall_n++; end
           else m_ready = 1'b1;
        default: m_ready = 1'b1;
      endcase
    end
    check({tag, " done_seen"}, 64'(done_at >= 0), 64'd1);
    check({tag, " err"}, 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    check({tag, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
    nw = (n + 3) / 4;
    check({tag, " words"}, 64'(got_data.size() - w0), 64'(nw));
    for (int w = 0; w < nw && w0 + w < got_data.size(); w++) begin
      ed = '0;
      for (int j = 0; j < 4; j++)
        if (4 * w + j < n) ed = ed | (32'(mem[4 * w + j]) << (8 * j));
      filled = (n - 4 * w > 4) ? 4 : n - 4 * w;
      check({tag, " data"}, 64'(got_data[w0 + w]), 64'(ed));
      check({tag, " keep"}, 64'(got_keep[w0 + w]), 64'((1 << filled) - 1));
      check({tag, " last"}, 64'(got_last[w0 + w]), 64'(w == nw - 1));
    end
    check({tag, " reads"}, 64'(adr_log.size() - a0), 64'(n));
    for (int i = 0; i < n && a0 + i < adr_log.size(); i++)
      check({tag, " adr"}, 64'(adr_log[a0 + i]), 64'(base + AW'(4 * i)));
  endtask

  initial begin
    int da, c0, v0, b0, s0, w0, n;
    logic [AW-1:0] b;
    reset = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; count = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom());
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst cyc", 64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
    check("rst valid", 64'(m_valid), 64'd0);
    check("rst stream", 64'({m_data, m_keep, m_last}), 64'd0);
    check("rst err", 64'(err), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("we/sel", 64'({wbm_we_o, wbm_sel_o}), 64'h0F);

    // count=4, fixed bytes, 1-cycle ack: one full word, 3 cycles per entry + OUT + DONE.
    b = 32'h8000_0000 | 32'(RESULT_WIN_OFFSET);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66;
    w0 = got_data.size();
    run_drain(4, b, 0, 0, "c4", da);
    check("c4 latency", 64'(da), 64'd14);
    if (got_data.size() > w0) check("c4 word", 64'(got_data[w0]), 64'h44332211);

    // count=6: full word then a two-lane last word.
    w0 = got_data.size();
    run_drain(6, b, 0, 0, "c6", da);
    if (got_data.size() > w0 + 1) check("c6 word1", 64'(got_data[w0 + 1]), 64'h00006655);

    // count=0: done two cycles after start, no bus traffic, no stream word.
    c0 = cyc_cycles; v0 = valid_cycles;
    run_drain(0, b, 0, 0, "c0", da);
    check("c0 latency", 64'(da), 64'd2);
    check("c0 cyc", 64'(cyc_cycles - c0), 64'd0);
    check("c0 valid", 64'(valid_cycles - v0), 64'd0);

    // Stray acks while idle must not disturb anything.
    c0 = cyc_cycles; v0 = valid_cycles;
    @(negedge clk); stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray busy", 64'(busy), 64'd0);
    check("stray act", 64'((cyc_cycles - c0) + (valid_cycles - v0)), 64'd0);

    // count=8 with the first word stalled 10 cycles.
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom());
    b0 = bus_viol; s0 = stall_viol; v0 = valid_cycles;
    run_drain(8, {$urandom(), 2'b00}, 0, 2, "stall", da);
    check("stall no_bus", 64'(bus_viol - b0), 64'd0);
    check("stall stable", 64'(stall_viol - s0), 64'd0);
    check("stall valid_cyc", 64'(valid_cycles - v0), 64'd12);

    // Reset during REQ of entry 2, then a count=1 drain.
    b = 32'h1234_5670;
    sl_base = b; sl_lat_max = 0;
    @(negedge clk); base_addr = b; count = 7'd4; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk); start = 1'b0; n++;
    end while (!(wbm_cyc_o && wbm_adr_o == b + 32'd8) && n < 50);
    check("rstmid reached", 64'(n < 50), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid cyc", 64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
    check("rstmid valid", 64'(m_valid), 64'd0);
    check("rstmid busy", 64'({busy, done}), 64'd0);
    reset = 1'b0;
    mem[0] = 8'hA5;
    run_drain(1, b, 0, 0, "after_rst", da);

    // Random drains, including a full 64-entry drain.
    for (int t = 0; t < 6; t++) begin
      n = (t == 0) ? 64 : int'($urandom_range(1, 64));
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom());
      run_drain(n, {$urandom(), 2'b00}, t % 3, 1, "rand", da);
    end

`ifdef REN_DRAIN_TIMEOUT_EN
    // Slave never acks: 16 REQ cycles, then abort with err and no stream output.
    sl_ack_en = 1'b0;
    s0 = stb_cycles; w0 = got_data.size(); c0 = done_cnt;
    @(negedge clk); base_addr = 32'h300; count = 7'd5; start = 1'b1; m_ready = 1'b1;
    da = -1; n = 0;
    while (da < 0 && n < 100) begin
      @(negedge clk); start = 1'b0; n++;
      if (done) da = n;
    end
    check("tmo done", 64'(da >= 0), 64'd1);
    check("tmo err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    check("tmo err_sticky", 64'(err), 64'd1);
    check("tmo req_cycles", 64'(stb_cycles - s0), 64'd16);
    check("tmo words", 64'(got_data.size() - w0), 64'd0);
    check("tmo pulses", 64'(done_cnt - c0), 64'd1);
    sl_ack_en = 1'b1;
    run_drain(3, 32'h300, 0, 0, "tmo_recover", da);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ren_conv_result_drain.md
Name: ren_conv_result_drain

Overview:
- Wishbone master placed directly downstream of the convolver's result RAM window.
- On start, reads N 8-bit result entries from the window with single read cycles.
- Packs every 4 bytes little-endian into a 32-bit word and presents the words on a valid/ready stream, with a last flag and byte-keep, for a downstream DMA/FIFO.
- Lets firmware collect results without per-byte CPU reads.

Parameters:
- RSLT_ADDR_WIDTH, 6, width of result entry index; maximum count is 2**RSLT_ADDR_WIDTH = 64.
- ADDR_WIDTH, 32, Wishbone address width.
- TIMEOUT_CYCLES, 16, ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a drain; ignored while busy
- base_addr  in  ADDR_WIDTH  byte address of result entry 0 (result window base, offset 0x300)
- count  in  RSLT_ADDR_WIDTH+1  number of entries to read, 0..64
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the drain completes or aborts
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  always 0
- wbm_sel_o  out  4  always 4'hF
- wbm_adr_o  out  ADDR_WIDTH  base_addr + 4*index
- wbm_dat_i  in  32  read data; bits [7:0] are used
- wbm_ack_i  in  1  Wishbone ack
- m_valid  out  1  stream word valid
- m_data  out  32  packed word; entry 4k+j sits in bits [8j+7:8j]
- m_keep  out  4  valid byte lanes (4'b0001, 4'b0011, 4'b0111 or 4'b1111)
- m_last  out  1  final word of the drain
- m_ready  in  1  downstream accept
- err  out  1  sticky abort flag (optional feature; tied 0 without it)

Behaviour:
- Reset: all outputs 0; state IDLE; index, lane and packer cleared. A reset mid-drain drops cyc/stb at the next edge; no partial word is emitted.
- start and count are sampled in IDLE only; base_addr and count are latched on the accepting edge.
- States:
  - IDLE
    - start with count==0 -> DONE (no bus traffic, no stream word).
    - start with count>0 -> REQ.
  - REQ
    - cyc=stb=1, adr = base + 4*index.
    - Hold until wbm_ack_i is sampled high.
    - On the ack edge: capture wbm_dat_i[7:0] into lane[index[1:0]], index++, cyc/stb go low on that same edge.
    - Go to OUT if lane==3 or index+1==count; otherwise go to GAP.
  - GAP
    - One idle bus cycle, cyc=stb=0; this guarantees the slave's ack has deasserted.
    - -> REQ.
  - OUT
    - m_valid=1, data/keep/last held stable until m_ready.
    - On handshake: clear the packer.
    - If index==count -> DONE, else -> GAP.
  - DONE: done=1 for one cycle, busy falls -> IDLE.
- Unfilled lanes read 0. m_keep = (1<<filled)-1. m_last=1 only on the word containing entry count-1.
- Latency: one entry costs a minimum of 3 cycles with a 1-cycle-ack slave (REQ, ack, GAP). A full word adds 1 OUT cycle when m_ready is already high.
- Backpressure: no further bus read is issued while OUT is waiting; at most one word is buffered.
- An ack arriving outside REQ is ignored.
- Wrap-around: index is RSLT_ADDR_WIDTH+1 bits wide. count=64 yields 16 words, the last with keep 4'hF.

Optional Feature:
- Macro: REN_DRAIN_TIMEOUT_EN.
- With the macro:
  - A counter runs in REQ and resets on each entry to REQ.
  - If it reaches TIMEOUT_CYCLES without an ack: cyc/stb drop, err is set (sticky until the next accepted start), and the block goes to DONE.
  - Any partial word is discarded; no m_last word is emitted.
- Without the macro: REQ waits indefinitely and err is constant 0.

Decomposition:
- Shared package ren_conv_pkg holds:
  - state encoding localparams (IDLE, REQ, GAP, OUT, DONE);
  - RESULT_WIN_OFFSET = 10'h300;
  - LANES = 4;
  - the keep-mask function.
- One sub-module, ren_byte_packer: lane register file, clear, keep/last generation.
- The FSM and Wishbone logic stay in the top module.

Test Plan:
- count=4, slave returns 8'h11, 8'h22, 8'h33, 8'h44 with 1-cycle ack -> one word: m_data=32'h44332211, keep=4'hF, last=1; addresses base+0x0..0xC; done pulses once.
- count=6 -> two words: 32'h44332211 (keep F, last 0), then 32'h00006655 (keep 4'b0011, last 1).
- count=0 -> done pulse 2 cycles after start; cyc never asserted; m_valid never asserted.
- m_ready held low 10 cycles on word 1 of a count=8 drain -> data stable throughout, no bus cycle during the stall, the second word follows.
- reset asserted during REQ of entry 2 -> cyc/stb/m_valid 0 next cycle; a new start with count=1 works normally.
- REN_DRAIN_TIMEOUT_EN, slave never acks -> after 16 REQ cycles, err=1, done pulse, no stream output.
